// File: rtl/threshold_detector_stage.sv
// Absolute-difference noise detector for the switching median filter.
// Two-stage valid/ready pipeline: S1 registers the input pair, S2 registers the classified result.
module threshold_detector_stage #(
    parameter int DATA_WIDTH   = 8,
    parameter int COUNT_WIDTH  = 20,
    parameter int DEFAULT_THR  = 20,
    parameter int DEFAULT_MODE = 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic                   In_SOF,
    input  logic [DATA_WIDTH-1:0]  CV,
    input  logic [DATA_WIDTH-1:0]  MV,
    input  logic [DATA_WIDTH-1:0]  Threshold,
    input  logic [1:0]             Mode,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic                   Out_SOF,
    output logic [DATA_WIDTH-1:0]  AD,
    output logic                   Noisy,
    output logic [DATA_WIDTH-1:0]  Pixel_Out,
    output logic [COUNT_WIDTH-1:0] Frame_Noisy_Count,
    output logic                   Count_Valid
);

    localparam logic [DATA_WIDTH-1:0]  PIX_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic                   s1_valid;
    logic                   s1_sof;
    logic [DATA_WIDTH-1:0]  s1_cv;
    logic [DATA_WIDTH-1:0]  s1_mv;
    logic                   s2_valid;

    logic [DATA_WIDTH-1:0]  thr_active;
    logic [1:0]             mode_active;
    logic [COUNT_WIDTH-1:0] run_count;

    logic                   s1_en;
    logic                   s2_en;
    logic                   in_xfer;
    logic                   out_xfer;

    logic [DATA_WIDTH:0]    diff;
    logic [DATA_WIDTH-1:0]  ad_next;
    logic                   extreme;
    logic                   over_thr;
    logic                   noisy_next;

    assign s2_en    = ~s2_valid | Out_Ready;
    assign s1_en    = ~s1_valid | s2_en;
    assign In_Ready = s1_en;
    assign in_xfer  = In_Valid & s1_en;
    assign out_xfer = s2_valid & Out_Ready;
    assign Out_Valid = s2_valid;

    // Sign bit of the widened subtraction selects which operand order gives |CV-MV|.
    always_comb begin
        diff       = {1'b0, s1_cv} - {1'b0, s1_mv};
        ad_next    = diff[DATA_WIDTH] ? (s1_mv - s1_cv) : diff[DATA_WIDTH-1:0];
        extreme    = (s1_cv == '0) | (s1_cv == PIX_MAX);
        over_thr   = ad_next > thr_active;
        noisy_next = 1'b0;
        case (mode_active)
            2'd0:    noisy_next = 1'b0;
            2'd1:    noisy_next = over_thr;
            2'd2:    noisy_next = extreme;
            default: noisy_next = extreme & over_thr;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            thr_active  <= DATA_WIDTH'(DEFAULT_THR);
            mode_active <= 2'(DEFAULT_MODE);
            s1_valid    <= 1'b0;
            s1_sof      <= 1'b0;
            s1_cv       <= '0;
            s1_mv       <= '0;
        end else begin
            // The SOF beat reaches S2 only after this latch, so it sees the new values.
            if (in_xfer && In_SOF) begin
                thr_active  <= Threshold;
                mode_active <= Mode;
            end
            if (s1_en) begin
                s1_valid <= In_Valid;
                if (In_Valid) begin
                    s1_sof <= In_SOF;
                    s1_cv  <= CV;
                    s1_mv  <= MV;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s2_valid  <= 1'b0;
            Out_SOF   <= 1'b0;
            AD        <= '0;
            Noisy     <= 1'b0;
            Pixel_Out <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                Out_SOF   <= s1_sof;
                AD        <= ad_next;
                Noisy     <= noisy_next;
                Pixel_Out <= noisy_next ? s1_mv : s1_cv;
            end
        end
    end

    // The SOF beat closes the previous frame and is itself the first beat of the new one.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_count         <= '0;
            Frame_Noisy_Count <= '0;
            Count_Valid       <= 1'b0;
        end else begin
            Count_Valid <= 1'b0;
            if (out_xfer) begin
                if (Out_SOF) begin
                    Frame_Noisy_Count <= run_count;
                    Count_Valid       <= 1'b1;
                    run_count         <= Noisy ? COUNT_WIDTH'(1) : '0;
                end else if (Noisy && (run_count != CNT_MAX)) begin
                    run_count <= run_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
